// File: rtl/core_scheduler.sv
// core_scheduler: per-core instruction sequencer.
// Steps one instruction at a time through FETCH, DECODE, REQUEST, WAIT,
// EXECUTE and UPDATE on the shared core_state bus, selects the core-wide PC
// from the per-thread next_pc values and raises done on RET.
// Optional feature: define SCHED_DIVERGENCE_CHECK_EN to build the sticky
// divergence detector; otherwise diverged is tied to 0.
module core_scheduler #(
    parameter int THREADS_PER_BLOCK = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [THREADS_PER_BLOCK-1:0]     thread_mask,
    input  logic [2:0]                       fetcher_state,
    input  logic [2*THREADS_PER_BLOCK-1:0]   lsu_state,
    input  logic                             decoded_ret,
    input  logic [8*THREADS_PER_BLOCK-1:0]   next_pc,
    output logic [2:0]                       core_state,
    output logic [7:0]                       current_pc,
    output logic                             done,
    output logic [15:0]                      instr_count,
    output logic                             diverged
);

    // State encoding is shared with the fetcher, decoder, LSUs, ALUs and PC units.
    localparam logic [2:0] S_IDLE    = 3'b000;
    localparam logic [2:0] S_FETCH   = 3'b001;
    localparam logic [2:0] S_DECODE  = 3'b010;
    localparam logic [2:0] S_REQUEST = 3'b011;
    localparam logic [2:0] S_WAIT    = 3'b100;
    localparam logic [2:0] S_EXECUTE = 3'b101;
    localparam logic [2:0] S_UPDATE  = 3'b110;
    localparam logic [2:0] S_DONE    = 3'b111;

    localparam logic [2:0] FETCHER_FETCHED = 3'b010;

    // Retired-instruction count sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] val);
        sat_inc = (val == 16'hFFFF) ? val : val + 16'd1;
    endfunction

    // next_pc of the lowest-index active thread; thread 0 when no thread is active.
    function automatic logic [7:0] select_pc(input logic [THREADS_PER_BLOCK-1:0]   mask,
                                             input logic [8*THREADS_PER_BLOCK-1:0] pcs);
        select_pc = pcs[7:0];
        for (int i = THREADS_PER_BLOCK - 1; i >= 0; i--) begin
            if (mask[i]) select_pc = pcs[8*i +: 8];
        end
    endfunction

    // An active LSU still in REQUESTING or WAITING keeps the core in WAIT.
    function automatic logic lsu_busy(input logic [THREADS_PER_BLOCK-1:0]   mask,
                                      input logic [2*THREADS_PER_BLOCK-1:0] lsu);
        lsu_busy = 1'b0;
        for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
            if (mask[i] && (lsu[2*i +: 2] == 2'b01 || lsu[2*i +: 2] == 2'b10))
                lsu_busy = 1'b1;
        end
    endfunction

    logic [2:0]  next_state;
    logic [7:0]  sel_pc;
    logic [7:0]  pc_nxt;
    logic        done_nxt;
    logic [15:0] cnt_nxt;

    assign sel_pc = select_pc(thread_mask, next_pc);

    // State register; reset overrides every transition.
    always_ff @(posedge clk) begin
        if (reset) core_state <= S_IDLE;
        else       core_state <= next_state;
    end

    // Next-state decode for the instruction sequence.
    always_comb begin
        next_state = core_state;
        case (core_state)
            S_IDLE:    if (start) next_state = S_FETCH;
            S_FETCH:   if (fetcher_state == FETCHER_FETCHED) next_state = S_DECODE;
            S_DECODE:  next_state = S_REQUEST;
            S_REQUEST: next_state = S_WAIT;
            S_WAIT:    if (!lsu_busy(thread_mask, lsu_state)) next_state = S_EXECUTE;
            S_EXECUTE: next_state = S_UPDATE;
            S_UPDATE:  next_state = decoded_ret ? S_DONE : S_FETCH;
            default:   next_state = S_DONE;
        endcase
    end

    // Output updates happen only in UPDATE; everything else holds.
    always_comb begin
        pc_nxt   = current_pc;
        done_nxt = done;
        cnt_nxt  = instr_count;
        if (core_state == S_UPDATE) begin
            cnt_nxt = sat_inc(instr_count);
            if (decoded_ret) done_nxt = 1'b1;
            else             pc_nxt   = sel_pc;
        end
    end

    // Registered outputs so consumers never see combinational glitches.
    always_ff @(posedge clk) begin
        if (reset) begin
            current_pc  <= 8'h00;
            done        <= 1'b0;
            instr_count <= 16'h0000;
        end else begin
            current_pc  <= pc_nxt;
            done        <= done_nxt;
            instr_count <= cnt_nxt;
        end
    end

`ifdef SCHED_DIVERGENCE_CHECK_EN
    // True when some active thread wants a different PC than the one selected.
    function automatic logic pc_mismatch(input logic [THREADS_PER_BLOCK-1:0]   mask,
                                         input logic [8*THREADS_PER_BLOCK-1:0] pcs,
                                         input logic [7:0]                     sel);
        pc_mismatch = 1'b0;
        for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
            if (mask[i] && pcs[8*i +: 8] != sel) pc_mismatch = 1'b1;
        end
    endfunction

    // Sticky divergence flag, sampled on non-RET UPDATE cycles only.
    always_ff @(posedge clk) begin
        if (reset)
            diverged <= 1'b0;
        else if (core_state == S_UPDATE && !decoded_ret &&
                 pc_mismatch(thread_mask, next_pc, sel_pc))
            diverged <= 1'b1;
    end
`else
    assign diverged = 1'b0;
`endif

endmodule

// File: tb/tb_core_scheduler.sv
// tb_core_scheduler: directed-vector bench for core_scheduler.
module tb_core_scheduler;

    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_REQUEST = 3'd3,
                           S_WAIT = 3'd4, S_EXECUTE = 3'd5, S_UPDATE = 3'd6, S_DONE = 3'd7;

`ifdef SCHED_DIVERGENCE_CHECK_EN
    localparam logic DIV_EXP = 1'b1;
`else
    localparam logic DIV_EXP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  thread_mask;
    logic [2:0]  fetcher_state;
    logic [7:0]  lsu_state;
    logic        decoded_ret;
    logic [31:0] next_pc;
    logic [2:0]  core_state;
    logic [7:0]  current_pc;
    logic        done;
    logic [15:0] instr_count;
    logic        diverged;

    logic        npc_auto;
    logic [31:0] npc_manual;

    int vectors     = 0;
    int miscompares = 0;
    int cnt;

    core_scheduler #(.THREADS_PER_BLOCK(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .thread_mask   (thread_mask),
        .fetcher_state (fetcher_state),
        .lsu_state     (lsu_state),
        .decoded_ret   (decoded_ret),
        .next_pc       (next_pc),
        .core_state    (core_state),
        .current_pc    (current_pc),
        .done          (done),
        .instr_count   (instr_count),
        .diverged      (diverged)
    );

    always #5 clk = ~clk;

    // PC units modelled as straight-line code (PC+1 on every thread) unless overridden.
    always_comb begin
        if (npc_auto) next_pc = {4{current_pc + 8'd1}};
        else          next_pc = npc_manual;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, ".state"}, 32'(core_state), 32'(S_IDLE));
        check_val({tag, ".pc"},    32'(current_pc), 32'h00);
        check_val({tag, ".done"},  32'(done), 32'd0);
        check_val({tag, ".count"}, 32'(instr_count), 32'd0);
        check_val({tag, ".div"},   32'(diverged), 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; thread_mask = 4'b1111; fetcher_state = 3'b010;
        lsu_state = 8'h00; decoded_ret = 1'b0; npc_auto = 1'b1; npc_manual = 32'h0;
        step(); step();
        reset = 1'b0;
        check_reset_vals("reset");

        // Straight-line code: state walks 1..6 twice, PC 0->1->2.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 12; k++) begin
            check_val($sformatf("seq.state%0d", k), 32'(core_state), 32'(k % 6 + 1));
            if (k == 6) check_val("seq.pc1", 32'(current_pc), 32'h01);
            step();
        end
        check_val("seq.pc2",    32'(current_pc), 32'h02);
        check_val("seq.count2", 32'(instr_count), 32'd2);

        // Load stall on active thread 2: WAIT lasts 6 cycles.
        step(); step();
        check_val("stall.req", 32'(core_state), 32'(S_REQUEST));
        lsu_state = 8'b0010_0000;
        cnt = 0;
        step();
        if (core_state == S_WAIT) cnt++;
        for (int k = 0; k < 5; k++) begin
            step();
            if (core_state == S_WAIT) cnt++;
        end
        lsu_state = 8'b0011_0000;
        step();
        check_val("stall.exec",  32'(core_state), 32'(S_EXECUTE));
        check_val("stall.waits", 32'(cnt), 32'd6);
        lsu_state = 8'h00;
        step(); step();
        check_val("stall.pc3", 32'(current_pc), 32'h03);

        // Same stall on masked-off thread 2: WAIT lasts 1 cycle.
        thread_mask = 4'b1011;
        lsu_state   = 8'b0010_0000;
        step(); step(); step();
        check_val("mask.wait", 32'(core_state), 32'(S_WAIT));
        step();
        check_val("mask.exec", 32'(core_state), 32'(S_EXECUTE));
        step(); step();
        lsu_state = 8'h00;
        check_val("mask.pc4",    32'(current_pc), 32'h04);
        check_val("mask.count4", 32'(instr_count), 32'd4);
        check_val("mask.div0",   32'(diverged), 32'd0);

        // Branch with mask 1100: thread 2 wins, thread 3 disagrees.
        thread_mask = 4'b1100;
        npc_auto    = 1'b0;
        npc_manual  = {8'h07, 8'h20, 8'h05, 8'h05};
        repeat (5) step();
        check_val("br.update", 32'(core_state), 32'(S_UPDATE));
        check_val("br.divpre", 32'(diverged), 32'd0);
        step();
        check_val("br.pc",    32'(current_pc), 32'h20);
        check_val("br.count", 32'(instr_count), 32'd5);
        check_val("br.div",   32'(diverged), 32'(DIV_EXP));
        npc_auto = 1'b1;
        repeat (6) step();
        check_val("br.pc21",    32'(current_pc), 32'h21);
        check_val("br.divstky", 32'(diverged), 32'(DIV_EXP));

        // Reset asserted during WAIT.
        step(); step(); step();
        check_val("rstw.wait", 32'(core_state), 32'(S_WAIT));
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_reset_vals("rstw");
        thread_mask = 4'b1111;
        start = 1'b1;
        step();
        start = 1'b0;
        check_val("rstw.fetch", 32'(core_state), 32'(S_FETCH));
        check_val("rstw.pc0",   32'(current_pc), 32'h00);

        // Three instructions to PC 3, then RET.
        repeat (18) step();
        check_val("ret.pc3", 32'(current_pc), 32'h03);
        decoded_ret = 1'b1;
        repeat (5) step();
        check_val("ret.update", 32'(core_state), 32'(S_UPDATE));
        check_val("ret.done0",  32'(done), 32'd0);
        step();
        check_val("ret.state", 32'(core_state), 32'(S_DONE));
        check_val("ret.done",  32'(done), 32'd1);
        check_val("ret.pc",    32'(current_pc), 32'h03);
        check_val("ret.count", 32'(instr_count), 32'd4);
        decoded_ret = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        check_val("ret.hold.state", 32'(core_state), 32'(S_DONE));
        check_val("ret.hold.done",  32'(done), 32'd1);
        check_val("ret.hold.pc",    32'(current_pc), 32'h03);
        check_val("ret.hold.count", 32'(instr_count), 32'd4);

        // Fetch stall of 10 cycles, then an all-zero mask passing WAIT with busy LSUs.
        reset = 1'b1;
        step();
        reset = 1'b0;
        fetcher_state = 3'b000;
        start = 1'b1;
        step();
        start = 1'b0;
        cnt = (core_state == S_FETCH) ? 1 : 0;
        for (int k = 0; k < 9; k++) begin
            step();
            if (core_state == S_FETCH) cnt++;
        end
        fetcher_state = 3'b010;
        step();
        check_val("fst.cycles", 32'(cnt), 32'd10);
        check_val("fst.decode", 32'(core_state), 32'(S_DECODE));
        thread_mask = 4'b0000;
        lsu_state   = 8'b1010_1010;
        npc_auto    = 1'b0;
        npc_manual  = {8'h99, 8'h99, 8'h99, 8'h42};
        step(); step();
        check_val("m0.wait", 32'(core_state), 32'(S_WAIT));
        step();
        check_val("m0.exec", 32'(core_state), 32'(S_EXECUTE));
        step(); step();
        check_val("m0.fetch", 32'(core_state), 32'(S_FETCH));
        check_val("m0.pc",    32'(current_pc), 32'h42);
        check_val("m0.div",   32'(diverged), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/core_scheduler.md
# core_scheduler

Per-core instruction sequencer for the compute core. It drives the shared `core_state` bus that the fetcher, decoder, LSUs, ALUs and per-thread PC units key off, advancing one instruction through FETCH → DECODE → REQUEST → WAIT → EXECUTE → UPDATE. It selects the core-wide `current_pc` from the per-thread `next_pc` values and flags block completion on RET.

## Interface
- `THREADS_PER_BLOCK`, default 4: number of thread lanes, which equals the number of PC units and LSUs.
- `clk` input 1: core clock.
- `reset` input 1: synchronous, active-high; one clock; all state is updated on the rising edge of `clk`.
- `start` input 1: launch pulse; only sampled in IDLE.
- `thread_mask` input THREADS_PER_BLOCK: bit i=1 means thread i is active. Static while not IDLE.
- `fetcher_state` input 3: fetcher FSM; 3'b010 = FETCHED.
- `lsu_state` input 2*THREADS_PER_BLOCK: thread i at bits [2i+1:2i]. Encoding: 00 IDLE, 01 REQUESTING, 10 WAITING, 11 DONE.
- `decoded_ret` input 1: current instruction is RET.
- `next_pc` input 8*THREADS_PER_BLOCK: thread i at bits [8i+7:8i], from the PC units.
- `core_state` output 3: current state.
- `current_pc` output 8: PC of the instruction in flight.
- `done` output 1: block finished.
- `instr_count` output 16: retired-instruction counter.
- `diverged` output 1: sticky divergence flag (see Configuration).

## Operation
- State encoding, fixed and shared with consumers: IDLE 3'b000, FETCH 3'b001, DECODE 3'b010, REQUEST 3'b011, WAIT 3'b100, EXECUTE 3'b101, UPDATE 3'b110, DONE 3'b111.
- IDLE: `start`=1 → FETCH.
- FETCH: hold until `fetcher_state`==3'b010, then → DECODE.
- DECODE → REQUEST, REQUEST → WAIT: unconditional, 1 cycle each.
- WAIT: hold while any active thread has `lsu_state` 01 or 10. Otherwise → EXECUTE. Inactive threads are ignored. An all-zero mask passes immediately.
- EXECUTE → UPDATE: unconditional. PC units compute `next_pc` in this state.
- UPDATE, when `decoded_ret`=1: → DONE and set `done`=1. `current_pc` is unchanged.
- UPDATE, otherwise: `current_pc` ← `next_pc` of the lowest-index active thread (thread 0 if the mask is zero), then → FETCH.
- `instr_count` increments on every UPDATE cycle, including RET. It saturates at 16'hFFFF.
- DONE: terminal. `done` holds at 1, `start` is ignored, and only `reset` leaves this state.
- `start` is ignored in every state except IDLE.

## Timing
- Reset values: `core_state`=IDLE, `current_pc`=8'h00, `done`=0, `instr_count`=0, `diverged`=0.
- Reset mid-operation takes priority over every transition. Next cycle is IDLE with all outputs at their reset values.
- All outputs are registered, and `core_state` changes only on `clk` edges.
- Minimum instruction period is 6 cycles (FETCH through UPDATE), reached when FETCHED arrives in the first FETCH cycle and WAIT clears immediately.
- `start` high in cycle N gives `core_state`=FETCH in cycle N+1.
- `current_pc` updates in the cycle after UPDATE, coincident with entering FETCH.
- WAIT evaluates `lsu_state` in its own cycle. The first WAIT cycle sees the LSU state registered at the end of REQUEST.

## Configuration
- Macro `SCHED_DIVERGENCE_CHECK_EN`.
- Defined: in UPDATE with `decoded_ret`=0, `diverged` ← 1 if any active thread's `next_pc` differs from the selected one. The flag is sticky until reset. Selection and sequencing are unaffected.
- Undefined: `diverged` is tied to 0 and no comparison logic is built.

## Test plan
- Reset, then `start`, straight-line code: `fetcher_state` FETCHED in the first FETCH cycle, LSUs idle, `next_pc`=PC+1 → `core_state` cycles 1,2,3,4,5,6 repeating every 6 cycles; `current_pc` 0→1→2; `instr_count` increments once per loop.
- Load stall: thread 2 `lsu_state`=10 for 5 cycles, then 11 → WAIT lasts 6 cycles. The same stall on masked-off thread 2 (`thread_mask`=4'b1011) → WAIT lasts 1 cycle.
- Branch with `thread_mask`=4'b1100: `next_pc` thread 2=8'h20, threads 0/1=8'h05 → `current_pc`=8'h20. With the macro, thread 3=8'h07 → `diverged`=1, sticky. Without the macro, `diverged` stays 0.
- RET at PC 3 → DONE after UPDATE, `done`=1, `current_pc` stays 3, `instr_count`=4. A later `start` pulse causes no change.
- Reset asserted during WAIT → next cycle IDLE, all outputs at reset values. Then `start` → FETCH with `current_pc`=0.
- Fetch stall: FETCHED delayed 10 cycles → FETCH held 10 cycles, then DECODE.
